tow_referee: RTL and testbench
==============================

// Module: tow_referee
// PURPOSE
//  Game sequencer for the tug-of-war board: owns the rope position and arbitrates pbl/pbr presses into single moves.
//  Sequences splash -> blank -> play -> win, and drives the 7-LED bar. Sits between the button inputs and the LED mux in fullTop.
//  Replaces ad-hoc position logic; the scorer/LED mux consume leds_out, win_l and win_r.
// PARAMETERS
//  SPLASH_CYC   256  clocks the splash pattern 7'b1100011 is held after reset release
//  BLANK_CYC    128  clocks all-off (7'b0000000) between splash and play
//  LOCKOUT_CYC  4    clocks after an accepted move during which new press edges are dropped
//  CNT_W        16   phase/lockout counter width; must hold max(SPLASH_CYC,BLANK_CYC,LOCKOUT_CYC)
// PORTS
//  CLK_I     in   1  system clock (~512 Hz board clock)
//  rst       in   1  asynchronous reset, active-low (0 = reset)
//  pbl       in   1  left push-button, asynchronous, level-high = pressed
//  pbr       in   1  right push-button, asynchronous, level-high = pressed
//  leds_out  out  7  LED bar; bit6 = L3 ... bit3 = N ... bit0 = R3
//  pos       out  3  rope position 0..6 (0 = R3, 3 = N, 6 = L3)
//  win_l     out  1  high while in LWIN
//  win_r     out  1  high while in RWIN
//  playing   out  1  high while presses are accepted (PLAY and lockout expired)
// BEHAVIOUR
//  Reset (rst=0, async): state=SPLASH, counter=0, pos=3, leds_out=7'b1100011, win_l=win_r=playing=0.
//   Sync flops clear to 0, so a button held through reset produces no edge until released and re-pressed.
//  Input path: each button uses a 2-flop synchronizer plus one edge flop; rise = sync & ~edge_q.
//   A press asserted before CLK_I edge k is seen as rise in cycle k+2; leds_out updates at edge k+3.
//  FSM states:
//   SPLASH: leds=1100011. After SPLASH_CYC clocks -> BLANK, counter=0.
//   BLANK:  leds=0000000. After BLANK_CYC clocks -> PLAY, pos=3.
//   PLAY:   leds = one-hot 1<<pos.
//    rise_l only -> pos+1; rise_r only -> pos-1.
//    rise_l & rise_r in the same cycle -> tie: no move, no lockout.
//    rise_l at pos=6 -> LWIN. rise_r at pos=0 -> RWIN. pos saturates, never wraps.
//    Each accepted move loads lockout=LOCKOUT_CYC; rises are ignored while lockout!=0 (not queued).
//    Held buttons never repeat; only rising edges count.
//   LWIN: leds=1110000, win_l=1. RWIN: leds=0000111, win_r=1. Both are terminal until rst.
//  Edges during SPLASH/BLANK/LWIN/RWIN are discarded.
//  playing = (state==PLAY) && (lockout==0).
//  All outputs are registered; no combinational path from pbl/pbr to any output.
//  Counters compare with ==(PARAM-1); CNT_W overflow is impossible by the parameter rule.
//  rst mid-game (any state): immediate return to SPLASH values above; no residual lockout or pending edge.
// STRUCTURE
//  tow_pkg: state enum {SPLASH,BLANK,PLAY,LWIN,RWIN} (3 bits), LED constants LED_SPLASH=7'b1100011,
//   LED_BLANK=7'b0, LED_LWIN=7'b1110000, LED_RWIN=7'b0000111, POS_N=3, POS_MAX=6.
//  Sub-module tow_press_edge (one instance per button): 2-flop sync + rise detect, ports CLK_I, rst, btn, rise.
//  tow_referee: FSM, phase counter, lockout counter, pos register, LED encode.
// TESTING
//  Reset/start: rst=0 for 100 clk then 1 -> leds 1100011 for SPLASH_CYC, 0000000 for BLANK_CYC,
//   then 0001000; playing=1.
//  Right win: 3 single pbr presses (1 clk wide, spaced > LOCKOUT_CYC+3) -> 0000100, 0000010, 0000001;
//   4th press -> 0000111, win_r=1; later pbl presses -> no change.
//  Recovery/left win: from R3, pbl presses -> 0000010 ... 0001000 ... 1000000; next -> 1110000, win_l=1.
//  Tie and hold: pbl,pbr rise same cycle at N -> stays 0001000; pbr held 50 clk -> exactly one move to 0000100.
//  Lockout: two pbl edges 2 clk apart (LOCKOUT_CYC=4) -> only one move; press during BLANK -> ignored.
//  Mid-game reset: at pos=5 pulse rst low 1 clk -> leds 1100011 immediately (async), full sequence repeats to N.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war referee: game states,
// LED bar patterns and rope position limits.
package tow_pkg;

  typedef enum logic [2:0] {
    SPLASH = 3'd0,
    BLANK  = 3'd1,
    PLAY   = 3'd2,
    LWIN   = 3'd3,
    RWIN   = 3'd4
  } tow_state_e;

  localparam logic [6:0] LED_SPLASH = 7'b1100011;
  localparam logic [6:0] LED_BLANK  = 7'b0000000;
  localparam logic [6:0] LED_LWIN   = 7'b1110000;
  localparam logic [6:0] LED_RWIN   = 7'b0000111;

  localparam logic [2:0] POS_N   = 3'd3;
  localparam logic [2:0] POS_MAX = 3'd6;
  localparam logic [2:0] POS_MIN = 3'd0;

  // LED bar pattern for a given game state; during play the rope is one lit LED.
  function automatic logic [6:0] led_encode(input tow_state_e st, input logic [2:0] pos);
    logic [6:0] leds;
    leds = LED_BLANK;
    case (st)
      SPLASH:  leds = LED_SPLASH;
      BLANK:   leds = LED_BLANK;
      PLAY:    leds = 7'b0000001 << pos;
      LWIN:    leds = LED_LWIN;
      RWIN:    leds = LED_RWIN;
      default: leds = LED_BLANK;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/tow_press_edge.sv
// Push-button front end: two-flop synchronizer followed by a rising-edge
// detector, so each physical press yields a single-cycle rise pulse.
module tow_press_edge (
  input  logic CLK_I,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q,  edge_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
  end

  // NOTE: clearing the chain to 0 means a button held through reset looks
  // released, so it produces no rise until it is let go and pressed again.
  always_ff @(posedge CLK_I or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour, which is what makes this a shift chain.
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
    end
  end

  assign rise = sync2_q & ~edge_q;

endmodule

// File: rtl/tow_referee.sv
// Tug-of-war game sequencer: splash -> blank -> play -> win, owning the rope
// position, press arbitration with lockout, and the registered LED bar.
module tow_referee
  import tow_pkg::*;
#(
  parameter int SPLASH_CYC  = 256,
  parameter int BLANK_CYC   = 128,
  parameter int LOCKOUT_CYC = 4,
  parameter int CNT_W       = 16
) (
  input  logic       CLK_I,
  input  logic       rst,
  input  logic       pbl,
  input  logic       pbr,
  output logic [6:0] leds_out,
  output logic [2:0] pos,
  output logic       win_l,
  output logic       win_r,
  output logic       playing
);

  localparam logic [CNT_W-1:0] SPLASH_LAST = CNT_W'(SPLASH_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCKOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;

  logic rise_l, rise_r;

  tow_press_edge u_edge_l (
    .CLK_I (CLK_I),
    .rst   (rst),
    .btn   (pbl),
    .rise  (rise_l)
  );

  tow_press_edge u_edge_r (
    .CLK_I (CLK_I),
    .rst   (rst),
    .btn   (pbr),
    .rise  (rise_r)
  );

  tow_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] lock_q,  lock_d;
  logic [2:0]       pos_q,   pos_d;
  logic [6:0]       leds_q,  leds_d;
  logic             win_l_q, win_l_d;
  logic             win_r_q, win_r_d;
  logic             playing_q, playing_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    pos_d   = pos_q;

    case (state_q)
      SPLASH: begin
        if (cnt_q == SPLASH_LAST) begin
          state_d = BLANK;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = PLAY;
          cnt_d   = CNT_ZERO;
          pos_d   = POS_N;
          lock_d  = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PLAY: begin
        // Rises arriving during lockout are dropped, not deferred.
        if (lock_q != CNT_ZERO) begin
          lock_d = lock_q - CNT_ONE;
        end else if (rise_l && !rise_r) begin
          if (pos_q == POS_MAX) begin
            state_d = LWIN;
          end else begin
            pos_d  = pos_q + 3'd1;
            lock_d = LOCK_LOAD;
          end
        end else if (rise_r && !rise_l) begin
          if (pos_q == POS_MIN) begin
            state_d = RWIN;
          end else begin
            pos_d  = pos_q - 3'd1;
            lock_d = LOCK_LOAD;
          end
        end
      end

      LWIN, RWIN: begin
        state_d = state_q;
      end

      default: begin
        state_d = SPLASH;
        cnt_d   = CNT_ZERO;
        lock_d  = CNT_ZERO;
        pos_d   = POS_N;
      end
    endcase
  end

  // Outputs are registered from the current state, one clock behind it.
  always_comb begin
    leds_d    = led_encode(state_q, pos_q);
    win_l_d   = (state_q == LWIN);
    win_r_d   = (state_q == RWIN);
    playing_d = (state_q == PLAY) && (lock_q == CNT_ZERO);
  end

  always_ff @(posedge CLK_I or negedge rst) begin
    if (!rst) begin
      state_q   <= SPLASH;
      cnt_q     <= CNT_ZERO;
      lock_q    <= CNT_ZERO;
      pos_q     <= POS_N;
      leds_q    <= LED_SPLASH;
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      pos_q     <= pos_d;
      leds_q    <= leds_d;
      win_l_q   <= win_l_d;
      win_r_q   <= win_r_d;
      playing_q <= playing_d;
    end
  end

  assign leds_out = leds_q;
  assign pos      = pos_q;
  assign win_l    = win_l_q;
  assign win_r    = win_r_q;
  assign playing  = playing_q;

endmodule

// File: tb/tb_tow_referee.sv
// Self-checking bench for tow_referee: directed game scenarios plus random
// button activity, compared every clock against a game-level reference model.
module tb_tow_referee;

  localparam int SPLASH = 256;
  localparam int BLANK  = 128;
  localparam int LOCK   = 4;
  localparam int PLAY_START = SPLASH + BLANK;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pbl = 1'b0;
  logic       pbr = 1'b0;
  logic [6:0] leds_out;
  logic [2:0] pos;
  logic       win_l, win_r, playing;

  tow_referee dut (
    .CLK_I    (clk),
    .rst      (rst),
    .pbl      (pbl),
    .pbr      (pbr),
    .leds_out (leds_out),
    .pos      (pos),
    .win_l    (win_l),
    .win_r    (win_r),
    .playing  (playing)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: edges since reset release, recent input samples,
  // rope position, winner (0 none, 1 left, 2 right), edge of last move.
  int         n;
  logic [3:0] hist_l, hist_r;
  int         m_pos;
  int         m_win;
  int         m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      if (tests_failed <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    hist_l = '0;
    hist_r = '0;
    m_pos  = 3;
    m_win  = 0;
    m_last = -100;
  endtask

  // Expected LED bar given the game situation after edge k.
  function automatic logic [6:0] leds_for(input int k);
    logic [6:0] one = 7'b0000001;
    if (m_win == 1)            return 7'b1110000;
    if (m_win == 2)            return 7'b0000111;
    if (k < SPLASH)            return 7'b1100011;
    if (k < PLAY_START)        return 7'b0000000;
    return one << m_pos;
  endfunction

  // One clock: drive inputs, advance the model, compare all outputs.
  task automatic step(input logic l, input logic r);
    int         k;
    logic [6:0] e_leds;
    logic       e_wl, e_wr, e_play, rl, rr;
    pbl = l;
    pbr = r;
    @(posedge clk);
    n++;
    k      = n - 1;
    e_leds = leds_for(k);
    e_wl   = (m_win == 1);
    e_wr   = (m_win == 2);
    e_play = (k >= PLAY_START) && (m_win == 0) && (k >= m_last + LOCK);
    hist_l = {hist_l[2:0], l};
    hist_r = {hist_r[2:0], r};
    rl = hist_l[2] & ~hist_l[3];
    rr = hist_r[2] & ~hist_r[3];
    if (e_play && (rl != rr)) begin
      if (rl) begin
        if (m_pos == 6) m_win = 1;
        else begin m_pos++; m_last = n; end
      end else begin
        if (m_pos == 0) m_win = 2;
        else begin m_pos--; m_last = n; end
      end
    end
    #1;
    check("leds",    32'(leds_out), 32'(e_leds));
    check("pos",     32'(pos),      32'(m_pos));
    check("win_l",   32'(win_l),    32'(e_wl));
    check("win_r",   32'(win_r),    32'(e_wr));
    check("playing", 32'(playing),  32'(e_play));
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) step(1'b0, 1'b0);
  endtask

  task automatic press(input logic l, input logic r);
    step(l, r);
    idle(8);
  endtask

  // Assert reset asynchronously, check the reset values at once, hold, release.
  task automatic do_reset(input int cycles);
    pbl = 1'b0;
    pbr = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_leds",    32'(leds_out), 32'(7'b1100011));
    check("rst_pos",     32'(pos),      32'd3);
    check("rst_flags",   32'({win_l, win_r, playing}), 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic run_to_play();
    while (n < PLAY_START + 2) step(1'b0, 1'b0);
  endtask

  task automatic random_game(input int cycles);
    logic l, r;
    l = 1'b0;
    r = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 9) == 0) l = ~l;
      if ($urandom_range(0, 9) == 0) r = ~r;
      step(l, r);
    end
  endtask

  initial begin
    logic [6:0] r_exp [3];
    logic [6:0] l_exp [6];
    r_exp = '{7'b0000100, 7'b0000010, 7'b0000001};
    l_exp = '{7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000};
    model_reset();
    #2;

    // Game 1: start-up, tie, long hold, lockout, then reset mid-game.
    do_reset(100);
    run_to_play();
    check("start_n",   32'(leds_out), 32'(7'b0001000));
    check("start_playing", 32'(playing), 32'd1);
    step(1'b1, 1'b1);
    idle(8);
    check("tie_stays_n", 32'(leds_out), 32'(7'b0001000));
    repeat (50) step(1'b0, 1'b1);
    idle(8);
    check("hold_one_move", 32'(leds_out), 32'(7'b0000100));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(8);
    check("lockout_one_move", 32'(leds_out), 32'(7'b0001000));
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("pos_five", 32'(pos), 32'd5);
    do_reset(1);

    // Game 2: full restart, then right win and ignored presses afterwards.
    run_to_play();
    check("restart_n", 32'(leds_out), 32'(7'b0001000));
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b1);
      check($sformatf("r_press%0d", i), 32'(leds_out), 32'(r_exp[i]));
    end
    press(1'b0, 1'b1);
    check("r_win_leds", 32'(leds_out), 32'(7'b0000111));
    check("r_win_flag", 32'(win_r), 32'd1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("r_win_terminal", 32'(leds_out), 32'(7'b0000111));

    // Game 3: press during blank is dropped, walk to R3 and back to a left win.
    do_reset(20);
    idle(300);
    step(1'b1, 1'b0);
    run_to_play();
    check("blank_press_ignored", 32'(leds_out), 32'(7'b0001000));
    repeat (3) press(1'b0, 1'b1);
    check("at_r3", 32'(leds_out), 32'(7'b0000001));
    for (int i = 0; i < 6; i++) begin
      press(1'b1, 1'b0);
      check($sformatf("l_press%0d", i), 32'(leds_out), 32'(l_exp[i]));
    end
    press(1'b1, 1'b0);
    check("l_win_leds", 32'(leds_out), 32'(7'b1110000));
    check("l_win_flag", 32'(win_l), 32'd1);

    // Games 4-6: random button activity through every phase.
    for (int g = 0; g < 3; g++) begin
      do_reset(5);
      random_game(700);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
